seq_mag_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator. Successor to the 4-bit equality cell.
- Compares two WIDTH-bit operands SLICE bits per cycle, most significant slice first.
- Reports eq/lt/gt in unsigned or two's-complement signed mode, with a start/busy/done handshake.
- Sits beside the mips8 ALU for branch and set-less-than evaluation. Optional early exit trades constant-time operation for latency.

---
 rtl/seq_mag_comparator_pkg.sv | 34 +++
 rtl/seq_mag_comparator_cmp_slice.sv | 36 +++
 rtl/seq_mag_comparator.sv | 157 +++++++++++++++
 tb/tb_seq_mag_comparator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mag_comparator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mag_comparator_pkg
// Description : Shared types, result encodings and sizing helpers for the
//               sequential magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mag_comparator_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Result encodings, packed as {eq, lt, gt}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  // Number of slices an operand is split into
  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Width of the slice index counter; never narrower than one bit
  function automatic int calc_idx_w(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage : seq_mag_comparator_pkg
`default_nettype wire

// File: rtl/seq_mag_comparator_cmp_slice.sv
`default_nettype none
// ============================================================================
// Module      : seq_mag_comparator_cmp_slice
// Description : Combinational SLICE-bit compare. For the top slice of a
//               signed compare both MSBs are inverted, which maps two's
//               complement ordering onto unsigned ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mag_comparator_cmp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] sa,
  input  logic [SLICE-1:0] sb,
  input  logic             signed_top,
  output logic             s_eq,
  output logic             s_lt
);

  logic [SLICE-1:0] w_msb_mask;
  logic [SLICE-1:0] w_ua;
  logic [SLICE-1:0] w_ub;

  // Mask selecting only the slice MSB when this is the signed top slice
  always_comb begin
    w_msb_mask            = '0;
    w_msb_mask[SLICE-1]   = signed_top;
  end

  assign w_ua = sa ^ w_msb_mask;
  assign w_ub = sb ^ w_msb_mask;

  assign s_eq = (sa == sb);
  assign s_lt = (w_ua < w_ub);

endmodule : seq_mag_comparator_cmp_slice
`default_nettype wire

// File: rtl/seq_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module      : seq_mag_comparator
// Description : Multi-cycle eq/lt/gt comparator, MS slice first, with
//               start/busy/done handshake and optional early exit.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SLICE      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int IDXW   = calc_idx_w(NSLICE);
  localparam logic [IDXW-1:0] C_TOP_IDX = IDXW'(NSLICE - 1);
  localparam logic [IDXW-1:0] C_IDX_ONE = IDXW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             dec_lt_q, dec_lt_d;
  logic [2:0]       res_q, res_d;

  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic             w_signed_top;
  logic             w_s_eq;
  logic             w_s_lt;
  logic             w_diff;

  // Select the slice addressed by the index from both latched operands
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == i[IDXW-1:0]) begin
        w_sa = a_q[i*SLICE +: SLICE];
        w_sb = b_q[i*SLICE +: SLICE];
      end
    end
  end

  assign w_signed_top = signed_q & (idx_q == C_TOP_IDX);

  seq_mag_comparator_cmp_slice #(
    .SLICE (SLICE)
  ) u_cmp_slice (
    .sa         (w_sa),
    .sb         (w_sb),
    .signed_top (w_signed_top),
    .s_eq       (w_s_eq),
    .s_lt       (w_s_lt)
  );

  // A difference only counts while no earlier (more significant) slice decided
  assign w_diff = ~decided_q & ~w_s_eq;

  // Next-state, operand latch and result decision
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    dec_lt_d  = dec_lt_q;
    res_d     = res_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          signed_d  = is_signed;
          idx_d     = C_TOP_IDX;
          decided_d = 1'b0;
          dec_lt_d  = 1'b0;
          state_d   = ST_CMP;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_CMP: begin
        if (w_diff && (EARLY_EXIT != 0)) begin
          res_d   = w_s_lt ? RES_LT : RES_GT;
          state_d = ST_DONE;
        end else begin
          if (w_diff) begin
            decided_d = 1'b1;
            dec_lt_d  = w_s_lt;
          end
          if (idx_q == '0) begin
            if (decided_d) begin
              res_d = dec_lt_d ? RES_LT : RES_GT;
            end else begin
              res_d = RES_EQ;
            end
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q - C_IDX_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      dec_lt_q  <= 1'b0;
      res_q     <= RES_NONE;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      signed_q  <= signed_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      dec_lt_q  <= dec_lt_d;
      res_q     <= res_d;
    end
  end

  assign busy = (state_q == ST_CMP);
  assign done = (state_q == ST_DONE);
  assign eq   = res_q[2];
  assign lt   = res_q[1];
  assign gt   = res_q[0];

endmodule : seq_mag_comparator
`default_nettype wire

// File: tb/tb_seq_mag_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mag_comparator
// Description : Self-checking bench for seq_mag_comparator. Two 8-bit
//               instances (early exit on/off) share stimulus; a 32-bit
//               instance covers asynchronous reset during a compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mag_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_b;
  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy_e, done_e, busy_n, done_n;
  logic [2:0]  res_e, res_n;
  logic        start32, sgn32;
  logic [31:0] a32, b32;
  logic        busy_w, done_w;
  logic [2:0]  res_w;

  int n_chk  = 0;
  int n_fail = 0;

  seq_mag_comparator #(.WIDTH(8), .SLICE(4), .EARLY_EXIT(1)) u_dut_ee1 (
    .clk(clk), .reset_b(reset_b), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .busy(busy_e), .done(done_e),
    .eq(res_e[2]), .lt(res_e[1]), .gt(res_e[0])
  );

  seq_mag_comparator #(.WIDTH(8), .SLICE(4), .EARLY_EXIT(0)) u_dut_ee0 (
    .clk(clk), .reset_b(reset_b), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .busy(busy_n), .done(done_n),
    .eq(res_n[2]), .lt(res_n[1]), .gt(res_n[0])
  );

  seq_mag_comparator #(.WIDTH(32), .SLICE(4), .EARLY_EXIT(1)) u_dut_w32 (
    .clk(clk), .reset_b(reset_b), .start(start32), .is_signed(sgn32),
    .a(a32), .b(b32), .busy(busy_w), .done(done_w),
    .eq(res_w[2]), .lt(res_w[1]), .gt(res_w[0])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference {eq,lt,gt} from plain integer ordering
  function automatic logic [2:0] ref_res(input logic [63:0] x, input logic [63:0] y,
                                         input logic sgn, input int w);
    longint vx, vy;
    vx = longint'(x);
    vy = longint'(y);
    if (sgn && x[w-1]) vx = vx - (longint'(1) << w);
    if (sgn && y[w-1]) vy = vy - (longint'(1) << w);
    if (vx == vy) return 3'b100;
    if (vx < vy)  return 3'b010;
    return 3'b001;
  endfunction

  // Reference latency: first differing 4-bit slice from the top, or all slices
  function automatic int ref_lat(input logic [63:0] x, input logic [63:0] y,
                                 input int w, input bit ee);
    int n;
    n = w / 4;
    if (!ee) return n;
    for (int k = 1; k <= n; k++) begin
      if (((x >> ((n - k) * 4)) & 64'hF) != ((y >> ((n - k) * 4)) & 64'hF)) return k;
    end
    return n;
  endfunction

  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic s);
    a8 = x; b8 = y; sgn8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("busy_ee1_accept", busy_e, 1);
    check("busy_ee0_accept", busy_n, 1);
  endtask

  task automatic wait8(input logic [7:0] x, input logic [7:0] y, input logic s,
                       input bit poke, input bit tail);
    int lat_e, lat_n;
    logic [2:0] r_e, r_n, exp;
    lat_e = 0; lat_n = 0; r_e = '0; r_n = '0;
    // operands change after acceptance; must be ignored
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~s;
    for (int cyc = 1; cyc <= 8 && (lat_e == 0 || lat_n == 0); cyc++) begin
      if (poke && cyc == 2 && busy_e && busy_n) start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      if (done_e && lat_e == 0) begin lat_e = cyc; r_e = res_e; end
      if (done_n && lat_n == 0) begin lat_n = cyc; r_n = res_n; end
    end
    exp = ref_res(64'(x), 64'(y), s, 8);
    check("lat_ee1", 64'(lat_e), 64'(ref_lat(64'(x), 64'(y), 8, 1'b1)));
    check("lat_ee0", 64'(lat_n), 64'(ref_lat(64'(x), 64'(y), 8, 1'b0)));
    check("res_ee1", 64'(r_e), 64'(exp));
    check("res_ee0", 64'(r_n), 64'(exp));
    if (tail) begin
      @(posedge clk); #1;
      check("done_pulse_ee1", done_e, 0);
      check("done_pulse_ee0", done_n, 0);
      check("hold_ee1", 64'(res_e), 64'(exp));
      check("hold_ee0", 64'(res_n), 64'(exp));
    end
  endtask

  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic s);
    int lat;
    logic [2:0] r;
    lat = 0; r = '0;
    a32 = x; b32 = y; sgn32 = s; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom;
    for (int cyc = 1; cyc <= 12 && lat == 0; cyc++) begin
      @(posedge clk); #1;
      if (done_w) begin lat = cyc; r = res_w; end
    end
    check("lat_w32", 64'(lat), 64'(ref_lat(64'(x), 64'(y), 32, 1'b1)));
    check("res_w32", 64'(r), 64'(ref_res(64'(x), 64'(y), s, 32)));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    int         seen_done;
    reset_b = 1'b0;
    start8 = 0; sgn8 = 0; a8 = 0; b8 = 0;
    start32 = 0; sgn32 = 0; a32 = 0; b32 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ee1_outs", {busy_e, done_e, res_e}, 5'b0);
    check("rst_ee0_outs", {busy_n, done_n, res_n}, 5'b0);
    check("rst_w32_outs", {busy_w, done_w, res_w}, 5'b0);
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk); #1;

    // Directed operands
    issue8(8'h5A, 8'h5A, 0); wait8(8'h5A, 8'h5A, 0, 0, 1);
    issue8(8'h3A, 8'h5A, 0); wait8(8'h3A, 8'h5A, 0, 0, 1);
    issue8(8'h5B, 8'h5A, 0); wait8(8'h5B, 8'h5A, 0, 0, 1);
    issue8(8'h80, 8'h7F, 1); wait8(8'h80, 8'h7F, 1, 0, 1);
    issue8(8'h80, 8'h7F, 0); wait8(8'h80, 8'h7F, 0, 0, 1);
    issue8(8'hFF, 8'hFE, 1); wait8(8'hFF, 8'hFE, 1, 0, 1);
    issue8(8'h10, 8'h20, 0); wait8(8'h10, 8'h20, 0, 0, 1);
    issue8(8'h1F, 8'h20, 0); wait8(8'h1F, 8'h20, 0, 0, 1);
    issue8(8'hE1, 8'hE9, 1); wait8(8'hE1, 8'hE9, 1, 1, 1);

    // Back-to-back: start held through DONE, no IDLE cycle in between
    issue8(8'hC3, 8'hC3, 1); wait8(8'hC3, 8'hC3, 1, 0, 0);
    issue8(8'h07, 8'h0C, 0); wait8(8'h07, 8'h0C, 0, 0, 1);

    // Randomized operands, sometimes sharing the top slice, with start pokes
    for (int t = 0; t < 60; t++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 2) == 0) rb[7:4] = ra[7:4];
      if ($urandom_range(0, 5) == 0) rb = ra;
      rs = 1'($urandom);
      issue8(ra, rb, rs);
      wait8(ra, rb, rs, 1'($urandom), 1'($urandom));
    end

    // 32-bit: produce a result, then abort an equal compare with reset
    run32(32'h1000_0000, 32'h2000_0000, 0);
    a32 = 32'hDEAD_BEEF; b32 = 32'hDEAD_BEEF; sgn32 = 0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("w32_busy_mid", busy_w, 1);
    reset_b = 1'b0;
    #1;
    check("w32_async_clear", {busy_w, done_w, res_w}, 5'b0);
    @(posedge clk); #1;
    check("w32_in_reset", {busy_w, done_w, res_w}, 5'b0);
    @(negedge clk);
    reset_b = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done_w) seen_done++;
    end
    check("w32_no_done_after_abort", 64'(seen_done), 0);
    run32(32'h0123_4567, 32'h0123_4567, 0);
    run32(32'h8000_0000, 32'h0000_0001, 1);
    run32(32'h8000_0000, 32'h0000_0001, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_seq_mag_comparator
`default_nettype wire
